// File: rtl/perf_disp_pkg.sv
// Shared definitions for the performance-counter display: source select
// codes, display geometry and the hex-to-seven-segment pattern table.
package perf_disp_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;
  localparam int IDX_W      = 3;

  // Source select encoding on the sel port
  typedef enum logic [1:0] {
    SEL_DISP   = 2'b00,
    SEL_CYCLE  = 2'b01,
    SEL_BRANCH = 2'b10,
    SEL_JMP    = 2'b11
  } sel_t;

  // Segment field with every segment dark (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational decoder from one hex nibble to its active-low
// seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
  import perf_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup shared with the rest of the display logic
  always_comb begin
    pattern = hex2seg(nibble);
  end

endmodule

// File: rtl/perf_counter_display.sv
// Selects one of four 32-bit counter/display sources into a hold register
// (optionally frozen) and scans it as eight hex digits onto an active-low
// multiplexed seven-segment display.
module perf_counter_display
  import perf_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_LZ = 0
)(
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        sel,
  input  logic              freeze,
  input  logic [DATA_W-1:0] disp_data,
  input  logic [DATA_W-1:0] count_cycle,
  input  logic [DATA_W-1:0] count_b,
  input  logic [DATA_W-1:0] count_j,
  output logic [DATA_W-1:0] shown,
  output logic [7:0]        an,
  output logic [7:0]        seg
);

  // A divide-by-one prescaler still needs a one-bit register
  localparam int               PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] hold;
  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shifted;
  logic [NIB_W-1:0]  nibble;
  logic [6:0]        pattern;
  logic              blank;
  logic [7:0]        an_next;
  logic [7:0]        seg_next;

  // Source multiplexer driven by sel
  always_comb begin
    src = disp_data;
    case (sel)
      SEL_DISP:   src = disp_data;
      SEL_CYCLE:  src = count_cycle;
      SEL_BRANCH: src = count_b;
      SEL_JMP:    src = count_j;
      default:    src = disp_data;
    endcase
  end

  // Hold register: tracks the selected source unless frozen
  always_ff @(posedge clk) begin
    if (clr) begin
      hold <= '0;
    end else if (!freeze) begin
      hold <= src;
    end
  end

  assign shown = hold;

  // Prescaler sets how long each digit stays lit
  always_ff @(posedge clk) begin
    if (clr) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == PRE_MAX);

  // Digit index walks right to left and wraps naturally after digit 7
  always_ff @(posedge clk) begin
    if (clr) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx + 1'b1;
    end
  end

  // Pick the nibble for the current digit; the shifted word doubles as the
  // leading-zero test since everything from this digit upward is in it
  always_comb begin
    shifted = hold >> {idx, 2'b00};
    nibble  = shifted[NIB_W-1:0];
    blank   = (BLANK_LZ != 0) && (idx != '0) && (shifted == '0);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // Next display drive: one-hot-low digit enable, pattern, freeze marker
  always_comb begin
    an_next       = ~(8'b1 << idx);
    seg_next[6:0] = blank ? SEG_BLANK : pattern;
    seg_next[7]   = ~((idx == '0) && freeze);
  end

  // Registered outputs keep the pin drive glitch-free; reset darkens all
  always_ff @(posedge clk) begin
    if (clr) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_display.sv
// Self-checking bench: two instances (no blanking / blanking, different scan
// rates) driven by shared stimulus and compared every cycle against a
// behavioural model of the display.
module tb_perf_counter_display;

  logic        clk;
  logic        clr;
  logic [1:0]  sel;
  logic        freeze;
  logic [31:0] disp_data;
  logic [31:0] count_cycle;
  logic [31:0] count_b;
  logic [31:0] count_j;

  logic [31:0] shown_a, shown_b;
  logic [7:0]  an_a, an_b;
  logic [7:0]  seg_a, seg_b;

  int tests;
  int fails;

  // model state per instance: 0 = SCAN_DIV 2 no blanking, 1 = SCAN_DIV 3 blanking
  int          div_m   [2];
  bit          blank_m [2];
  logic [31:0] hold_m  [2];
  int          pre_m   [2];
  int          idx_m   [2];
  logic [7:0]  an_m    [2];
  logic [7:0]  seg_m   [2];
  logic [7:0]  hex_tab [16];

  perf_counter_display #(.SCAN_DIV(2), .BLANK_LZ(0)) dut_a (
    .clk(clk), .clr(clr), .sel(sel), .freeze(freeze),
    .disp_data(disp_data), .count_cycle(count_cycle),
    .count_b(count_b), .count_j(count_j),
    .shown(shown_a), .an(an_a), .seg(seg_a)
  );

  perf_counter_display #(.SCAN_DIV(3), .BLANK_LZ(1)) dut_b (
    .clk(clk), .clr(clr), .sel(sel), .freeze(freeze),
    .disp_data(disp_data), .count_cycle(count_cycle),
    .count_b(count_b), .count_j(count_j),
    .shown(shown_b), .an(an_b), .seg(seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_src(input logic [1:0] s);
    case (s)
      2'd0:    return disp_data;
      2'd1:    return count_cycle;
      2'd2:    return count_b;
      default: return count_j;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        hold_m[i] = 32'h0;
        pre_m[i]  = 0;
        idx_m[i]  = 0;
        an_m[i]   = 8'hFF;
        seg_m[i]  = 8'hFF;
      end else begin
        logic [31:0] upper;
        logic [3:0]  nib;
        logic        dp;
        upper    = hold_m[i] >> (4 * idx_m[i]);
        nib      = upper[3:0];
        dp       = !(idx_m[i] == 0 && freeze);
        an_m[i]  = 8'hFF ^ (8'd1 << idx_m[i]);
        if (blank_m[i] && idx_m[i] > 0 && upper == 0)
          seg_m[i] = {dp, 7'h7F};
        else
          seg_m[i] = {dp, hex_tab[nib][6:0]};
        if (!freeze) hold_m[i] = pick_src(sel);
        if (pre_m[i] == div_m[i] - 1) begin
          pre_m[i] = 0;
          idx_m[i] = (idx_m[i] + 1) % 8;
        end else begin
          pre_m[i] = pre_m[i] + 1;
        end
      end
    end
  endtask

  // One clock: edge, model update, sample shortly after the edge and compare
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("shown_a", shown_a, hold_m[0]);
    check("an_a",    {24'h0, an_a},  {24'h0, an_m[0]});
    check("seg_a",   {24'h0, seg_a}, {24'h0, seg_m[0]});
    check("shown_b", shown_b, hold_m[1]);
    check("an_b",    {24'h0, an_b},  {24'h0, an_m[1]});
    check("seg_b",   {24'h0, seg_b}, {24'h0, seg_m[1]});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [31:0] cyc_val;
    tests = 0;
    fails = 0;
    div_m[0] = 2; blank_m[0] = 1'b0;
    div_m[1] = 3; blank_m[1] = 1'b1;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    clr = 1'b1; sel = 2'd0; freeze = 1'b0;
    disp_data = 32'h0; count_cycle = 32'h0; count_b = 32'h0; count_j = 32'h0;
    #1;

    // reset for three cycles, then release
    steps(3);
    check("rst_an",    {24'h0, an_a}, 32'hFF);
    check("rst_seg",   {24'h0, seg_a}, 32'hFF);
    check("rst_shown", shown_a, 32'h0);
    clr = 1'b0;
    step();
    check("post_rst_an", {24'h0, an_a}, 32'hFE);

    // source mux: branch count
    count_b = 32'h0000_00A5; sel = 2'd2;
    step();
    check("mux_b_shown", shown_a, 32'h0000_00A5);
    steps(20);

    // scan order on a distinctive word
    disp_data = 32'h8765_4321; sel = 2'd0;
    steps(40);

    // freeze holds the snapshot while sel and sources move
    disp_data = 32'h0000_1234;
    step();
    freeze = 1'b1;
    step();
    count_cycle = 32'hDEAD_BEEF; sel = 2'd1;
    steps(24);
    check("freeze_shown", shown_a, 32'h0000_1234);
    freeze = 1'b0;
    step();
    check("unfreeze_shown", shown_a, 32'hDEAD_BEEF);
    steps(6);

    // leading-zero blanking patterns
    disp_data = 32'h0000_00F0; sel = 2'd0;
    steps(30);
    disp_data = 32'h0;
    steps(30);

    // mid-scan reset once digit 5 is active
    disp_data = 32'hCAFE_F00D;
    for (int k = 0; k < 100 && idx_m[0] != 5; k++) step();
    check("reach_idx5", idx_m[0], 5);
    clr = 1'b1;
    step();
    check("msr_an", {24'h0, an_a}, 32'hFF);
    clr = 1'b0;
    step();
    check("msr_an_next", {24'h0, an_a}, 32'hFE);

    // randomized traffic with occasional reset and freeze
    for (int n = 0; n < 3000; n++) begin
      clr    = ($urandom_range(63) == 0);
      freeze = ($urandom_range(3) == 0);
      sel    = 2'($urandom_range(3));
      disp_data   = $urandom >> $urandom_range(31);
      count_cycle = count_cycle + 32'($urandom_range(5));
      count_b     = $urandom >> $urandom_range(31);
      count_j     = (n % 16 == 0) ? 32'h0 : ($urandom >> $urandom_range(31));
      step();
    end

    cyc_val = count_cycle;
    clr = 1'b0; freeze = 1'b0; sel = 2'd1;
    step();
    check("final_cycle", shown_b, cyc_val);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
